stream_lane_scheduler: RTL and testbench

- Generalised N-way frame scheduler that spreads whole streaming frames (sop..eop, valid/ready) across NUM_LANES identical processing lanes (dct_preFFT_reod, dct_vecRot and similar) in round-robin order.
- Merges the lane outputs back into one stream in the same frame order.
- Replaces hand-written ping/pong muxing; NUM_LANES=2 is ping-pong.
- Adds correct backpressure, per-frame fftpts tracking and framing-error detection.

---
 rtl/stream_lane_scheduler.sv | 154 +++++++++++++++
 tb/tb_stream_lane_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_lane_scheduler.sv
// Round-robin frame scheduler: spreads whole sop..eop frames over NUM_LANES lanes
// and merges lane outputs back into a single stream in the original frame order.
module stream_lane_scheduler #(
  parameter int NUM_LANES = 2,
  parameter int wDataIn   = 16,
  parameter int wDataOut  = 16,
  parameter int wLane     = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sink_valid,
  output logic                            sink_ready,
  input  logic [1:0]                      sink_error,
  input  logic                            sink_sop,
  input  logic                            sink_eop,
  input  logic [wDataIn-1:0]              sink_real,
  input  logic [wDataIn-1:0]              sink_imag,
  input  logic [11:0]                     fftpts_in,
  output logic [NUM_LANES-1:0]            lane_sink_valid,
  input  logic [NUM_LANES-1:0]            lane_sink_ready,
  output logic [1:0]                      lane_sink_error,
  output logic                            lane_sink_sop,
  output logic                            lane_sink_eop,
  output logic [wDataIn-1:0]              lane_sink_real,
  output logic [wDataIn-1:0]              lane_sink_imag,
  output logic [NUM_LANES*12-1:0]         lane_fftpts,
  input  logic [NUM_LANES-1:0]            lane_source_valid,
  input  logic [NUM_LANES-1:0]            lane_source_sop,
  input  logic [NUM_LANES-1:0]            lane_source_eop,
  input  logic [NUM_LANES*2-1:0]          lane_source_error,
  input  logic [NUM_LANES*wDataOut-1:0]   lane_source_real,
  input  logic [NUM_LANES*wDataOut-1:0]   lane_source_imag,
  output logic [NUM_LANES-1:0]            lane_source_ready,
  output logic                            source_valid,
  input  logic                            source_ready,
  output logic                            source_sop,
  output logic                            source_eop,
  output logic [1:0]                      source_error,
  output logic [wDataOut-1:0]             source_real,
  output logic [wDataOut-1:0]             source_imag,
  output logic [11:0]                     fftpts_out,
  output logic                            err_framing
);

  logic [wLane-1:0]    disp_ptr;
  logic [wLane-1:0]    merge_ptr;
  logic                in_frame;
  logic                fwd;
  logic                accept;
  logic                sel_sink_ready;
  logic                out_open;
  logic                load;
  logic                m_valid;
  logic                m_sop;
  logic                m_eop;
  logic [1:0]          m_error;
  logic [wDataOut-1:0] m_real;
  logic [wDataOut-1:0] m_imag;
  logic [11:0]         m_fftpts;

  function automatic logic [wLane-1:0] next_lane(input logic [wLane-1:0] p);
    return (p == wLane'(NUM_LANES - 1)) ? '0 : p + wLane'(1);
  endfunction

  assign lane_sink_error = sink_error;
  assign lane_sink_sop   = sink_sop;
  assign lane_sink_eop   = sink_eop;
  assign lane_sink_real  = sink_real;
  assign lane_sink_imag  = sink_imag;

  // Dispatch and merge handshakes are combinational; gated by rst so they drop at once.
  always_comb begin
    fwd               = in_frame || sink_sop;
    out_open          = !source_valid || source_ready;
    sel_sink_ready    = 1'b0;
    lane_sink_valid   = '0;
    lane_source_ready = '0;
    m_valid           = 1'b0;
    m_sop             = 1'b0;
    m_eop             = 1'b0;
    m_error           = '0;
    m_real            = '0;
    m_imag            = '0;
    m_fftpts          = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (disp_ptr == wLane'(k)) begin
        sel_sink_ready     = lane_sink_ready[k];
        lane_sink_valid[k] = !rst && sink_valid && fwd;
      end
      if (merge_ptr == wLane'(k)) begin
        lane_source_ready[k] = !rst && out_open;
        m_valid  = lane_source_valid[k];
        m_sop    = lane_source_sop[k];
        m_eop    = lane_source_eop[k];
        m_error  = lane_source_error[k*2 +: 2];
        m_real   = lane_source_real[k*wDataOut +: wDataOut];
        m_imag   = lane_source_imag[k*wDataOut +: wDataOut];
        m_fftpts = lane_fftpts[k*12 +: 12];
      end
    end
    sink_ready = !rst && (sel_sink_ready || !fwd);
    accept     = sink_valid && sink_ready;
    load       = !rst && m_valid && out_open;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_ptr     <= '0;
      merge_ptr    <= '0;
      in_frame     <= 1'b0;
      lane_fftpts  <= '0;
      err_framing  <= 1'b0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_error <= '0;
      source_real  <= '0;
      source_imag  <= '0;
      fftpts_out   <= '0;
    end else begin
      // Beats outside a frame are swallowed and flagged rather than stalling upstream.
      if (accept) begin
        if (!fwd) begin
          err_framing <= 1'b1;
        end else begin
          if (sink_sop) begin
            if (in_frame) err_framing <= 1'b1;
            in_frame <= 1'b1;
            for (int k = 0; k < NUM_LANES; k++)
              if (disp_ptr == wLane'(k)) lane_fftpts[k*12 +: 12] <= fftpts_in;
          end
          if (sink_eop) begin
            in_frame <= 1'b0;
            disp_ptr <= next_lane(disp_ptr);
          end
        end
      end
      // Output register stage
      if (load) begin
        source_valid <= 1'b1;
        source_sop   <= m_sop;
        source_eop   <= m_eop;
        source_error <= m_error;
        source_real  <= m_real;
        source_imag  <= m_imag;
        fftpts_out   <= m_fftpts;
        if (m_eop) merge_ptr <= next_lane(merge_ptr);
      end else if (source_ready) begin
        source_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_lane_scheduler.sv
// Bench for stream_lane_scheduler with four FIFO-style lane models and an
// in-order scoreboard of expected source beats.
module tb_stream_lane_scheduler;
  localparam int NL = 4;

  logic clk = 1'b0;
  logic rst;
  logic sink_valid, sink_ready, sink_sop, sink_eop;
  logic [1:0] sink_error;
  logic [15:0] sink_real, sink_imag;
  logic [11:0] fftpts_in;
  logic [NL-1:0] lane_sink_valid, lane_sink_ready;
  logic [1:0] lane_sink_error;
  logic lane_sink_sop, lane_sink_eop;
  logic [15:0] lane_sink_real, lane_sink_imag;
  logic [NL*12-1:0] lane_fftpts;
  logic [NL-1:0] lane_source_valid, lane_source_sop, lane_source_eop, lane_source_ready;
  logic [NL*2-1:0] lane_source_error;
  logic [NL*16-1:0] lane_source_real, lane_source_imag;
  logic source_valid, source_ready, source_sop, source_eop, err_framing;
  logic [1:0] source_error;
  logic [15:0] source_real, source_imag;
  logic [11:0] fftpts_out;

  always #5 clk = ~clk;

  stream_lane_scheduler #(.NUM_LANES(NL), .wDataIn(16), .wDataOut(16), .wLane(2)) dut (
    .clk(clk), .rst(rst),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_error(sink_error),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
    .fftpts_in(fftpts_in),
    .lane_sink_valid(lane_sink_valid), .lane_sink_ready(lane_sink_ready),
    .lane_sink_error(lane_sink_error), .lane_sink_sop(lane_sink_sop), .lane_sink_eop(lane_sink_eop),
    .lane_sink_real(lane_sink_real), .lane_sink_imag(lane_sink_imag), .lane_fftpts(lane_fftpts),
    .lane_source_valid(lane_source_valid), .lane_source_sop(lane_source_sop),
    .lane_source_eop(lane_source_eop), .lane_source_error(lane_source_error),
    .lane_source_real(lane_source_real), .lane_source_imag(lane_source_imag),
    .lane_source_ready(lane_source_ready),
    .source_valid(source_valid), .source_ready(source_ready), .source_sop(source_sop),
    .source_eop(source_eop), .source_error(source_error), .source_real(source_real),
    .source_imag(source_imag), .fftpts_out(fftpts_out), .err_framing(err_framing)
  );

  int tests = 0;
  int fails = 0;
  logic [47:0] sb[$];
  int disp_m;
  logic in_frame_m;
  logic err_m;
  logic [11:0] fp_m[NL];
  int src_mode;
  logic [NL-1:0] lane_in_en, lane_out_en;
  int seq;
  int last_wait;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Lane model: stores a frame, accepts a new one only once drained.
  logic [35:0] mem[NL][64];
  int wp[NL], rp[NL];
  logic busy[NL];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NL; k++) begin
        wp[k] <= 0; rp[k] <= 0; busy[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NL; k++) begin
        if (lane_sink_valid[k] && lane_sink_ready[k]) begin
          mem[k][wp[k] % 64] <= {lane_sink_sop, lane_sink_eop, lane_sink_error,
                                 lane_sink_real, lane_sink_imag};
          wp[k] <= wp[k] + 1;
          if (lane_sink_eop) busy[k] <= 1'b0;
          else if (lane_sink_sop) busy[k] <= 1'b1;
        end
        if (lane_source_valid[k] && lane_source_ready[k]) rp[k] <= rp[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NL; k++) begin
      logic [35:0] b;
      b = mem[k][rp[k] % 64];
      lane_sink_ready[k]           = lane_in_en[k] && (busy[k] || wp[k] == rp[k]);
      lane_source_valid[k]         = lane_out_en[k] && (wp[k] != rp[k]);
      lane_source_sop[k]           = b[35];
      lane_source_eop[k]           = b[34];
      lane_source_error[k*2 +: 2]  = b[33:32];
      lane_source_real[k*16 +: 16] = b[31:16];
      lane_source_imag[k*16 +: 16] = b[15:0];
    end
    case (src_mode)
      0: source_ready = 1'b1;
      1: source_ready = !source_ready;
      2: source_ready = 1'($urandom_range(0, 1));
      default: source_ready = 1'b0;
    endcase
  end

  // Output monitor: in-order compare, hold stability, one-cycle load latency.
  logic hold_pending = 1'b0, lat_pending = 1'b0;
  logic [47:0] held;
  always @(negedge clk) begin
    logic [47:0] cur, exp;
    #2;
    if (rst) begin
      hold_pending = 1'b0;
      lat_pending  = 1'b0;
    end else begin
      cur = {source_sop, source_eop, source_error, source_real, source_imag, fftpts_out};
      if (hold_pending) check("hold", cur, held);
      if (lat_pending) check("lat", source_valid, 1);
      if (source_valid && source_ready) begin
        if (sb.size() == 0) check("extra_beat", 1, 0);
        else begin
          exp = sb.pop_front();
          check("beat", cur, exp);
        end
      end
      hold_pending = source_valid && !source_ready;
      held         = cur;
      lat_pending  = |(lane_source_valid & lane_source_ready);
    end
  end

  task automatic send_beat(input logic sop, input logic eop, input logic [11:0] fp,
                           input int bubbles);
    int n;
    logic fwd_m;
    logic [11:0] fp_e;
    seq++;
    repeat (bubbles) begin
      @(negedge clk);
      sink_valid = 1'b0;
    end
    @(negedge clk);
    sink_valid = 1'b1; sink_sop = sop; sink_eop = eop; fftpts_in = fp;
    sink_error = 2'(seq); sink_real = 16'(seq * 3); sink_imag = 16'(~seq);
    n = 0;
    #1;
    while (!sink_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    last_wait = n;
    if (n >= 300) check("accept_timeout", 1, 0);
    fwd_m = in_frame_m || sop;
    check("disp", lane_sink_valid, fwd_m ? (64'd1 << disp_m) : 64'd0);
    if (!fwd_m) err_m = 1'b1;
    else begin
      if (sop) begin
        if (in_frame_m) err_m = 1'b1;
        in_frame_m = 1'b1;
        fp_m[disp_m] = fp;
      end
      fp_e = fp_m[disp_m];
      sb.push_back({sop, eop, sink_error, sink_real, sink_imag, fp_e});
      if (eop) begin
        in_frame_m = 1'b0;
        disp_m = (disp_m + 1) % NL;
      end
    end
    @(posedge clk);
    #1 sink_valid = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [11:0] fp, input int maxbub);
    for (int i = 0; i < len; i++)
      send_beat(i == 0, i == len - 1, fp, maxbub > 0 ? int'($urandom_range(0, maxbub)) : 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic model_reset();
    sb.delete();
    disp_m = 0; in_frame_m = 1'b0; err_m = 1'b0;
    for (int k = 0; k < NL; k++) fp_m[k] = '0;
  endtask

  initial begin
    rst = 1'b1; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    sink_error = '0; sink_real = '0; sink_imag = '0; fftpts_in = '0;
    lane_in_en = '1; lane_out_en = '1; src_mode = 0; source_ready = 1'b1; seq = 0;
    model_reset();
    repeat (3) @(negedge clk);
    sink_valid = 1'b1; sink_sop = 1'b1;
    #1;
    check("rst_sink_ready", sink_ready, 0);
    check("rst_lane_sink_valid", lane_sink_valid, 0);
    check("rst_lane_source_ready", lane_source_ready, 0);
    check("rst_source_valid", source_valid, 0);
    check("rst_fftpts", {lane_fftpts, fftpts_out}, 0);
    check("rst_err", err_framing, 0);
    sink_valid = 1'b0; sink_sop = 1'b0;
    @(negedge clk);
    #3 rst = 1'b0;

    // Round robin with per-frame sizes
    send_frame(8, 12'd8, 0);
    send_frame(8, 12'd16, 0);
    send_frame(8, 12'd8, 0);
    send_frame(8, 12'd16, 0);
    drain();
    check("err_clean", err_framing, 0);

    // Lane 2 finishes before lane 1; merge must wait for lane 1
    lane_out_en[1] = 1'b0;
    for (int f = 0; f < 4; f++) send_frame(4, 12'(32 + f), 0);
    repeat (20) @(negedge clk);
    #1;
    check("blocked_ready", lane_source_ready, 4'b0010);
    check("blocked_valid", source_valid, 0);
    lane_out_en[1] = 1'b1;
    drain();

    // Backpressure with gappy input
    src_mode = 1;
    for (int f = 0; f < 3; f++) send_frame(int'($urandom_range(1, 10)), 12'(64 + f), 2);
    drain();
    src_mode = 2;
    for (int f = 0; f < 3; f++) send_frame(int'($urandom_range(1, 10)), 12'(128 + f), 2);
    drain();
    src_mode = 0;

    // Back-to-back single-beat frames
    for (int f = 0; f < 5; f++) begin
      send_beat(1'b1, 1'b1, 12'(200 + f), 0);
      check("b2b_wait", last_wait, 0);
    end
    drain();

    // Stray beat outside a frame, then a frame with a repeated sop
    send_beat(1'b0, 1'b0, 12'd0, 0);
    check("err_stray", err_framing, 1);
    send_beat(1'b1, 1'b0, 12'd48, 0);
    send_beat(1'b1, 1'b0, 12'd48, 0);
    send_beat(1'b0, 1'b1, 12'd48, 0);
    drain();
    check("err_sticky", err_framing, err_m);

    // Asynchronous reset in the middle of a frame
    src_mode = 3;
    send_beat(1'b1, 1'b0, 12'd64, 0);
    send_beat(1'b0, 1'b0, 12'd64, 0);
    send_beat(1'b0, 1'b0, 12'd64, 0);
    repeat (3) @(negedge clk);
    sink_valid = 1'b1; sink_sop = 1'b1; sink_eop = 1'b0;
    #1;
    check("pre_rst_source_valid", source_valid, 1);
    check("pre_rst_lane_sink_valid", lane_sink_valid, 64'd1 << disp_m);
    #2 rst = 1'b1;
    #1;
    check("async_source_valid", source_valid, 0);
    check("async_sink_ready", sink_ready, 0);
    check("async_lane_sink_valid", lane_sink_valid, 0);
    check("async_lane_source_ready", lane_source_ready, 0);
    check("async_fftpts", {lane_fftpts, fftpts_out}, 0);
    check("async_err", err_framing, 0);
    sink_valid = 1'b0; sink_sop = 1'b0;
    model_reset();
    src_mode = 0;
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    send_frame(3, 12'd100, 0);
    drain();
    check("post_rst_fftpts0", lane_fftpts[11:0], 12'd100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
